osd_overlay: RTL and testbench
==============================

// Module: osd_overlay
// PURPOSE
//  Downstream stage of the scandoubler. Overlays a 256x64 monochrome on-screen display onto its
//  pixel stream (pixel_ena, hs/vs/hb/vb, RGB at OUT_COLOR_DEPTH) and feeds the HDMI/RGB encoder.
//  Auto-measures the active area from hb/vb and centres the window in it.
//  The OSD bitmap is written by the MCU/SPI side through a byte-write port.
// PARAMETERS
//  OUT_COLOR_DEPTH  6   bits per colour, input and output
//  HCNT_W           12  width of active-pixel counter
//  VCNT_W           11  width of active-line counter
// PORTS
//  clk_sys     in   1        system clock, same as scandoubler; only clock
//  reset_n     in   1        asynchronous, active-low reset
//  pixel_ena   in   1        pixel clock enable from scandoubler; all video logic advances only on it
//  osd_enable  in   1        request OSD visible
//  osd_wr      in   1        bitmap byte write strobe, any clk_sys cycle
//  osd_addr    in   11       {row[2:0], col[7:0]}
//  osd_data    in   8        bit n = pixel line (row*8+n) at column col
//  hb_in,vb_in,hs_in,vs_in  in  1 each  blanking and syncs, active high
//  r_in,g_in,b_in           in  OUT_COLOR_DEPTH  pixel colour
//  hb_out,vb_out,hs_out,vs_out  out  1 each  inputs delayed 2 pixel_ena ticks
//  r_out,g_out,b_out        out  OUT_COLOR_DEPTH  overlaid colour, registered
// BEHAVIOUR
//  - Reset: all outputs 0; counters, h_active, v_active, h_start, v_start = 0; osd_vis = 0.
//    Bitmap RAM is not cleared.
//  - h_cnt: increments per pixel_ena while !hb_in. Cleared on hb_in rising.
//    At that edge h_active <= h_cnt.
//  - v_cnt: increments on each hb_in rising while !vb_in. Cleared on vb_in rising.
//    At that edge v_active <= v_cnt, and h_start/v_start are recomputed:
//    h_start = (h_active>=256) ? (h_active-256)>>1 : 0
//    v_start = (v_active>=64) ? (v_active-64)>>1 : 0
//    Both are stable for the whole next frame.
//  - osd_vis <= osd_enable, sampled only on vs_in rising edge (no mid-frame tearing).
//  - Stage 1 (pixel_ena): in_win = osd_vis & !hb_in & !vb_in
//    & h_cnt in [h_start, h_start+256) & v_cnt in [v_start, v_start+64).
//    h_off = h_cnt-h_start, v_off = v_cnt-v_start.
//    Drive RAM rd addr {v_off[5:3], h_off[7:0]}; register v_off[2:0], in_win, video, syncs.
//  - Stage 2 (pixel_ena): bit = rd_data[v_off[2:0]].
//    Colour: in_win & bit -> all ones (white); in_win & !bit -> background; else input.
//    Register all outputs.
//  - Latency: exactly 2 pixel_ena ticks for every output; no skew between sync, blank and colour.
//  - hb_out|vb_out forces r/g/b_out = 0.
//  - RAM: write port on any clk_sys cycle. Read is synchronous and read-first:
//    a same-cycle same-address write returns old data.
//  - Window overrunning the active area (h_active<256 or v_active<64) is truncated by blanking.
//    It never wraps: h_off uses full width, and in_win fails when h_off>=256.
//  - Counter saturation: h_cnt/v_cnt hold at all-ones and do not wrap.
//  - Reset mid-frame: window is at 0,0 and hidden until the first vs_in rise after
//    osd_enable=1; correct centring follows the first complete frame.
//  - pixel_ena low: all video registers hold.
// CONFIGURATION
//  OSD_ALPHA_EN defined: background = each input channel >>1 (50% dimmed, picture visible).
//  OSD_ALPHA_EN undefined: background = opaque r=g=0, b={2'b01,{OUT_COLOR_DEPTH-2{1'b0}}}.
//  Foreground and latency are identical in both builds.
// STRUCTURE
//  video_pkg: OSD_W=256, OSD_H=64, OSD_ADDR_W=11, OSD_ROWS=8, and the window-centring
//  function used here and by future overlay stages.
//  Sub-module osd_ram: 2048x8 simple dual-port RAM, one write port, one registered read port,
//  read-first, maps to a single block RAM.
// TESTING
//  1 Reset: reset_n low mid-line -> all outputs 0. After release with osd_enable=0:
//    out equals in delayed exactly 2 pixel_ena ticks.
//  2 Centring: 640x200 active area (hb/vb timed), osd_enable=1, write 8'hFF to addr 0.
//    Frame 2: white at h=192..192 column 0, lines 68..75 only.
//  3 Frame-sync enable: toggle osd_enable high mid-frame -> no change until next vs_in rise,
//    overlay from that frame on.
//  4 Small area: h_active=200, v_active=40 -> h_start=v_start=0.
//    Overlay is cut at blank and never reappears at line start.
//  5 Write collision: write addr 0x105 while it is read -> old byte shown this frame,
//    new byte next frame.
//  6 Background: pixel 6'h3E in window with bit 0.
//    OSD_ALPHA_EN -> 6'h1F.
//    Without OSD_ALPHA_EN -> r=g=0, b=6'h10.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video-overlay definitions: OSD geometry, sync bundle type and the
// window-centring helper used by this and later overlay stages.
package video_pkg;

  localparam int OSD_W      = 256;
  localparam int OSD_H      = 64;
  localparam int OSD_ADDR_W = 11;
  localparam int OSD_ROWS   = 8;
  localparam int OSD_DATA_W = 8;

  // Blanking and sync travel together through the pipeline
  typedef struct packed {
    logic hb;
    logic vb;
    logic hs;
    logic vs;
  } sync_t;

  // Offset that centres a window of 'size' inside 'active'; a window larger
  // than the area is pinned to the top/left edge instead of going negative.
  function automatic int unsigned win_start(input int unsigned active,
                                            input int unsigned size);
    if (active >= size) begin
      return (active - size) >> 1;
    end
    return 0;
  endfunction

endpackage

// File: rtl/osd_ram.sv
// OSD bitmap store: simple dual-port RAM, one write port and one registered,
// read-first read port. No reset so it maps onto a single block RAM.
module osd_ram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  // Write and read share the edge; the non-blocking read returns the old
  // word when both hit the same address in the same cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/osd_overlay.sv
// OSD overlay stage: measures the active area from hb/vb, centres a
// 256x64 monochrome window in it and mixes the bitmap into the pixel stream
// with a fixed two-tick latency on every output.
// Build option: OSD_ALPHA_EN selects a 50% dimmed background instead of the
// opaque blue one.
module osd_overlay
  import video_pkg::*;
#(
  parameter int OUT_COLOR_DEPTH = 6,
  parameter int HCNT_W          = 12,
  parameter int VCNT_W          = 11
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       pixel_ena,
  input  logic                       osd_enable,
  input  logic                       osd_wr,
  input  logic [OSD_ADDR_W-1:0]      osd_addr,
  input  logic [OSD_DATA_W-1:0]      osd_data,
  input  logic                       hb_in,
  input  logic                       vb_in,
  input  logic                       hs_in,
  input  logic                       vs_in,
  input  logic [OUT_COLOR_DEPTH-1:0] r_in,
  input  logic [OUT_COLOR_DEPTH-1:0] g_in,
  input  logic [OUT_COLOR_DEPTH-1:0] b_in,
  output logic                       hb_out,
  output logic                       vb_out,
  output logic                       hs_out,
  output logic                       vs_out,
  output logic [OUT_COLOR_DEPTH-1:0] r_out,
  output logic [OUT_COLOR_DEPTH-1:0] g_out,
  output logic [OUT_COLOR_DEPTH-1:0] b_out
);

  localparam logic [HCNT_W-1:0] OSD_W_H = HCNT_W'(OSD_W);
  localparam logic [VCNT_W-1:0] OSD_H_V = VCNT_W'(OSD_H);

  // ---------------------------------------------------------------------------
  // Active-area measurement and window placement
  // ---------------------------------------------------------------------------
  logic              hb_prev_q, vb_prev_q, vs_prev_q;
  logic              hb_rise, vb_rise, vs_rise;
  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [VCNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [HCNT_W-1:0] h_active_q, h_active_d;
  logic [VCNT_W-1:0] v_active_q, v_active_d;
  logic [HCNT_W-1:0] h_start_q, h_start_d;
  logic [VCNT_W-1:0] v_start_q, v_start_d;
  logic              osd_vis_q, osd_vis_d;

  assign hb_rise = hb_in & ~hb_prev_q;
  assign vb_rise = vb_in & ~vb_prev_q;
  assign vs_rise = vs_in & ~vs_prev_q;

  // Next-state for counters, measured size, window origin and visibility
  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    h_active_d = h_active_q;
    v_active_d = v_active_q;
    h_start_d  = h_start_q;
    v_start_d  = v_start_q;
    osd_vis_d  = osd_vis_q;

    // Pixels of the line; saturate rather than wrap on absurdly long lines
    if (hb_rise) begin
      h_active_d = h_cnt_q;
      h_cnt_d    = '0;
    end else if (!hb_in && (h_cnt_q != '1)) begin
      h_cnt_d = h_cnt_q + 1'b1;
    end

    // Lines of the frame. The window origin is latched here so it stays
    // fixed for the whole following frame; v_start uses the line count being
    // captured right now, h_start the width of the last complete line.
    if (vb_rise) begin
      v_active_d = v_cnt_q;
      v_cnt_d    = '0;
      h_start_d  = HCNT_W'(win_start(32'(h_active_q), OSD_W));
      v_start_d  = VCNT_W'(win_start(32'(v_cnt_q), OSD_H));
    end else if (hb_rise && !vb_in && (v_cnt_q != '1)) begin
      v_cnt_d = v_cnt_q + 1'b1;
    end

    // Visibility only changes at vsync so a frame is never half overlaid
    if (vs_rise) begin
      osd_vis_d = osd_enable;
    end
  end

  // Measurement state register, advances only with the pixel enable
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hb_prev_q  <= 1'b0;
      vb_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      h_active_q <= '0;
      v_active_q <= '0;
      h_start_q  <= '0;
      v_start_q  <= '0;
      osd_vis_q  <= 1'b0;
    end else if (pixel_ena) begin
      hb_prev_q  <= hb_in;
      vb_prev_q  <= vb_in;
      vs_prev_q  <= vs_in;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      h_active_q <= h_active_d;
      v_active_q <= v_active_d;
      h_start_q  <= h_start_d;
      v_start_q  <= v_start_d;
      osd_vis_q  <= osd_vis_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: window hit test and bitmap address
  // ---------------------------------------------------------------------------
  logic [HCNT_W-1:0]           h_off;
  logic [VCNT_W-1:0]           v_off;
  logic                        h_hit, v_hit, in_win;
  logic [OSD_ADDR_W-1:0]       rd_addr;
  logic [OSD_DATA_W-1:0]       rd_data;

  logic                        s1_in_win_q;
  logic [2:0]                  s1_line_q;
  sync_t                       s1_sync_q;
  logic [OUT_COLOR_DEPTH-1:0]  s1_r_q, s1_g_q, s1_b_q;

  // Offsets use the full counter width so a window running past the end of
  // a short line is clipped by the range test and never wraps to column 0.
  always_comb begin
    h_off   = h_cnt_q - h_start_q;
    v_off   = v_cnt_q - v_start_q;
    h_hit   = (h_cnt_q >= h_start_q) && (h_off < OSD_W_H);
    v_hit   = (v_cnt_q >= v_start_q) && (v_off < OSD_H_V);
    in_win  = osd_vis_q & ~hb_in & ~vb_in & h_hit & v_hit;
    rd_addr = {v_off[5:3], h_off[7:0]};
  end

  osd_ram #(
    .AW (OSD_ADDR_W),
    .DW (OSD_DATA_W)
  ) u_osd_ram (
    .clk_i     (clk_sys),
    .wr_en_i   (osd_wr),
    .wr_addr_i (osd_addr),
    .wr_data_i (osd_data),
    .rd_en_i   (pixel_ena),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Stage-1 pipeline register, aligned with the RAM read
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1_in_win_q <= 1'b0;
      s1_line_q   <= '0;
      s1_sync_q   <= '0;
      s1_r_q      <= '0;
      s1_g_q      <= '0;
      s1_b_q      <= '0;
    end else if (pixel_ena) begin
      s1_in_win_q <= in_win;
      s1_line_q   <= v_off[2:0];
      s1_sync_q   <= '{hb: hb_in, vb: vb_in, hs: hs_in, vs: vs_in};
      s1_r_q      <= r_in;
      s1_g_q      <= g_in;
      s1_b_q      <= b_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour mix and blanking
  // ---------------------------------------------------------------------------
  logic                       pix_bit;
  logic [OUT_COLOR_DEPTH-1:0] bg_r, bg_g, bg_b;
  logic [OUT_COLOR_DEPTH-1:0] r_d, g_d, b_d;
  sync_t                      out_sync_q;
  logic [OUT_COLOR_DEPTH-1:0] r_q, g_q, b_q;

  // Background colour behind clear bitmap pixels, then the output mux
  always_comb begin
    pix_bit = rd_data[s1_line_q];
`ifdef OSD_ALPHA_EN
    bg_r = s1_r_q >> 1;
    bg_g = s1_g_q >> 1;
    bg_b = s1_b_q >> 1;
`else
    bg_r = '0;
    bg_g = '0;
    bg_b = {2'b01, {(OUT_COLOR_DEPTH-2){1'b0}}};
`endif
    r_d = s1_r_q;
    g_d = s1_g_q;
    b_d = s1_b_q;
    if (s1_in_win_q) begin
      if (pix_bit) begin
        r_d = '1;
        g_d = '1;
        b_d = '1;
      end else begin
        r_d = bg_r;
        g_d = bg_g;
        b_d = bg_b;
      end
    end
    if (s1_sync_q.hb || s1_sync_q.vb) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // Output register; syncs and colour leave together
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_sync_q <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else if (pixel_ena) begin
      out_sync_q <= s1_sync_q;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign hb_out = out_sync_q.hb;
  assign vb_out = out_sync_q.vb;
  assign hs_out = out_sync_q.hs;
  assign vs_out = out_sync_q.vs;
  assign r_out  = r_q;
  assign g_out  = g_q;
  assign b_out  = b_q;

endmodule

// File: tb/tb_osd_overlay.sv
// Bench for osd_overlay: drives framed video of known geometry, predicts each
// output pixel from frame coordinates and the bitmap contents, and checks the
// DUT every cycle against that prediction plus a few literal pixels.
module tb_osd_overlay;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       pixel_ena = 1'b0;
  logic       osd_enable = 1'b0;
  logic       osd_wr = 1'b0;
  logic [10:0] osd_addr = '0;
  logic [7:0] osd_data = '0;
  logic       hb_in = 1'b0, vb_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [5:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hb_out, vb_out, hs_out, vs_out;
  logic [5:0] r_out, g_out, b_out;

  osd_overlay dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .pixel_ena  (pixel_ena),
    .osd_enable (osd_enable),
    .osd_wr     (osd_wr),
    .osd_addr   (osd_addr),
    .osd_data   (osd_data),
    .hb_in      (hb_in),
    .vb_in      (vb_in),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .hb_out     (hb_out),
    .vb_out     (vb_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic hb; logic vb; logic hs; logic vs;
    logic [5:0] r; logic [5:0] g; logic [5:0] b;
  } vid_t;

  typedef struct packed {
    vid_t v;
    logic pin;
    vid_t p;
  } exp_t;

  exp_t exp_pend = '0;
  exp_t exp_out  = '0;
  logic [7:0] bmp [2048];
  int n_checks = 0;
  int n_fail   = 0;
  int m_hs = 0, m_vs = 0;
  bit m_vis = 0;
  bit gaps_en = 0;
  int cur_frame = -1;

  function automatic vid_t mk(logic hb, logic vb, logic hs, logic vs,
                              logic [5:0] r, logic [5:0] g, logic [5:0] b);
    vid_t v;
    v = {hb, vb, hs, vs, r, g, b};
    return v;
  endfunction

  function automatic int centre(int act, int sz);
    return (act >= sz) ? (act - sz) / 2 : 0;
  endfunction

  function automatic logic [7:0] pat(int a);
    if (a == 0) return 8'hFF;
    if (a == 1 || a == 'h105) return 8'h00;
    return 8'((a * 37) ^ (a >> 2) ^ 'h5A);
  endfunction

  // Expected output for one input pixel at frame coordinates (x, y)
  function automatic vid_t model(logic hb, logic vb, logic hs, logic vs,
                                 int x, int y, logic [5:0] r, logic [5:0] g, logic [5:0] b);
    vid_t o;
    logic [7:0] byt;
    int col, ln;
    o = mk(hb, vb, hs, vs, r, g, b);
    if (hb || vb) begin
      o.r = 0; o.g = 0; o.b = 0;
    end else if (m_vis && x >= m_hs && x < m_hs + 256 && y >= m_vs && y < m_vs + 64) begin
      col = x - m_hs;
      ln  = y - m_vs;
      byt = bmp[(ln / 8) * 256 + col];
      if (byt[ln % 8]) begin
        o.r = 6'h3F; o.g = 6'h3F; o.b = 6'h3F;
      end else begin
`ifdef OSD_ALPHA_EN
        o.r = r >> 1; o.g = g >> 1; o.b = b >> 1;
`else
        o.r = 0; o.g = 0; o.b = 6'h10;
`endif
      end
    end
    return o;
  endfunction

  // Hand-computed pixels that pin the model down
  function automatic bit pin_at(int f, int x, int y, output vid_t v);
    v = '0;
    if (f == 0 && x == 0 && y == 0) begin v = mk(0,0,0,0, 6'h00, 6'h3E, 6'h00); return 1; end
    if (f == 1 && x == 4 && y == 2) begin v = mk(0,0,0,0, 6'h3F, 6'h3F, 6'h3F); return 1; end
    if (f == 1 && x == 3 && y == 2) begin v = mk(0,0,0,0, 6'h03, 6'h3E, 6'h06); return 1; end
    if (f == 1 && x == 4 && y == 66) begin v = mk(0,0,0,0, 6'h04, 6'h3E, 6'h06); return 1; end
`ifdef OSD_ALPHA_EN
    if (f == 1 && x == 5 && y == 2) begin v = mk(0,0,0,0, 6'h02, 6'h1F, 6'h03); return 1; end
    if (f == 1 && x == 9 && y == 17) begin v = mk(0,0,0,0, 6'h04, 6'h1F, 6'h19); return 1; end
`else
    if (f == 1 && x == 5 && y == 2) begin v = mk(0,0,0,0, 6'h00, 6'h00, 6'h10); return 1; end
    if (f == 1 && x == 9 && y == 17) begin v = mk(0,0,0,0, 6'h00, 6'h00, 6'h10); return 1; end
`endif
    if (f == 2 && x == 200 && y == 0) begin v = mk(1,0,0,0, 6'h00, 6'h00, 6'h00); return 1; end
    if (f == 3 && x == 0 && y == 0) begin v = mk(0,0,0,0, 6'h3F, 6'h3F, 6'h3F); return 1; end
    if (f == 3 && x == 5 && y == 15) begin v = mk(0,0,0,0, 6'h3F, 6'h3F, 6'h3F); return 1; end
    return 0;
  endfunction

  // Single compare process: outputs checked every cycle, away from the edge
  always @(negedge clk_sys) begin
    vid_t act;
    act = {hb_out, vb_out, hs_out, vs_out, r_out, g_out, b_out};
    n_checks++;
    if (act !== exp_out.v) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL stream @%0t: got %h expected %h", $time, act, exp_out.v);
    end
    if (exp_out.pin) begin
      n_checks++;
      if (act !== exp_out.p) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL pin @%0t: got %h expected %h", $time, act, exp_out.p);
      end
    end
  end

  // One enabled pixel tick, optionally preceded by a disabled cycle
  task automatic px(input logic hb, input logic vb, input logic hs, input logic vs,
                    input int x, input int y,
                    input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                    input bit wr, input logic [10:0] wa, input logic [7:0] wd);
    vid_t e, pv;
    bit pin;
    if (gaps_en && $urandom_range(0, 7) == 0) begin
      pixel_ena = 0;
      hb_in = ~hb; vb_in = ~vb; vs_in = ~vs; r_in = 6'h15; g_in = 6'h2B; b_in = 6'h0C;
      @(posedge clk_sys); #1;
    end
    pixel_ena = 1;
    hb_in = hb; vb_in = vb; hs_in = hs; vs_in = vs;
    r_in = r; g_in = g; b_in = b;
    osd_wr = wr; osd_addr = wa; osd_data = wd;
    e = model(hb, vb, hs, vs, x, y, r, g, b);
    pin = pin_at(cur_frame, x, y, pv);
    @(posedge clk_sys);
    exp_out  = exp_pend;
    exp_pend = '{v: e, pin: pin, p: pv};
    if (wr) bmp[wa] = wd;
    #1;
    pixel_ena = 0;
    osd_wr = 0;
  endtask

  // One video line: w active pixels then 4 blanking pixels with hsync in the middle
  task automatic line(input int w, input int y, input logic vb, input logic vsl);
    logic hb, hsy;
    logic [5:0] r, g, b;
    bit wr;
    for (int x = 0; x < w + 4; x++) begin
      hb  = (x >= w);
      hsy = (x == w + 1 || x == w + 2);
      r = hb ? 6'h2A : 6'(x);
      g = hb ? 6'h2A : 6'h3E;
      b = hb ? 6'h2A : 6'(y * 3);
      wr = (cur_frame == 1 && y == 17 && x == 9);
      px(hb, vb, hsy, vsl, x, y, r, g, b, wr, 11'h105, 8'h80);
    end
  endtask

  // Full frame: h active lines, then two vblank lines with vsync on the second
  task automatic frame(input int w, input int h);
    for (int y = 0; y < h; y++) begin
      if (cur_frame == 0 && y == 30) osd_enable = 1;
      line(w, y, 1'b0, 1'b0);
    end
    line(w, h, 1'b1, 1'b0);
    m_hs = centre(w, 256);
    m_vs = centre(h, 64);
    line(w, h + 1, 1'b1, 1'b1);
    m_vis = osd_enable;
    cur_frame++;
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1;

    // Load the whole bitmap with video held
    for (int a = 0; a < 2048; a++) begin
      osd_wr = 1; osd_addr = 11'(a); osd_data = pat(a);
      @(posedge clk_sys);
      bmp[a] = pat(a);
      #1;
    end
    osd_wr = 0;

    // Part of a line, then reset asserted mid-line with video still running
    for (int x = 0; x < 10; x++)
      px(1'b0, 1'b0, 1'b0, 1'b0, x, 0, 6'(x), 6'h3E, 6'h11, 1'b0, 11'h0, 8'h0);
    reset_n = 0;
    exp_out = '0; exp_pend = '0;
    m_hs = 0; m_vs = 0; m_vis = 0;
    pixel_ena = 1; r_in = 6'h33;
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1;
    pixel_ena = 0;

    // Restart from vertical blanking, then measured frames
    line(264, 0, 1'b1, 1'b0);
    line(264, 1, 1'b1, 1'b0);
    gaps_en = 1;
    cur_frame = 0;
    frame(264, 68);   // enable mid-frame: no overlay yet
    frame(264, 68);   // centred at 4,2; collision write on 0x105
    frame(200, 40);   // still 4,2; clipped by blanking
    frame(200, 40);   // 0,0 from the small area; new 0x105 byte visible
    gaps_en = 0;
    repeat (3) @(posedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
